// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise and debounce four active-low buttons, then emit
//            single-button press events and flag multi-button presses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [3:0] s_n,
  output logic       press,
  output logic [1:0] key,
  output logic       multi,
  output logic       idle
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] db_q;
  logic [3:0] db_d;
  logic [3:0] db_dly_q;
  logic [3:0] fall;
  logic [2:0] n_fall;
  logic [2:0] n_down;
  logic [1:0] fall_idx;

  state_t     state_q;
  state_t     state_d;
  logic       press_q;
  logic       press_d;
  logic       multi_q;
  logic       multi_d;
  logic [1:0] key_q;
  logic [1:0] key_d;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int j = 0; j < 4; j++) begin
      sum = sum + {2'b00, v[j]};
    end
    return sum;
  endfunction

  // Both synchroniser stages idle at 1 so reset looks like "all released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bit_d;

    // Any return to the stable level before the count completes restarts it.
    always_comb begin
      cnt_d = cnt_q;
      bit_d = db_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_MAX) begin
        bit_d = sync2_q[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign db_d[i] = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 4'hF;
      db_dly_q <= 4'hF;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  assign fall   = db_dly_q & ~db_q;
  assign n_fall = popcount4(fall);
  assign n_down = popcount4(~db_q);

  always_comb begin
    fall_idx = 2'd0;
    for (int j = 0; j < 4; j++) begin
      if (fall[j]) begin
        fall_idx = 2'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
    multi_d = 1'b0;
    key_d   = key_q;
    case (state_q)
      S_IDLE: begin
        // Two or more down at once (including same-edge falls) is never a guess.
        if (n_down >= 3'd2) begin
          multi_d = 1'b1;
          state_d = S_LOCK;
        end else if (n_fall == 3'd1 && n_down == 3'd1) begin
          press_d = 1'b1;
          key_d   = fall_idx;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (|fall) begin
          multi_d = 1'b1;
          state_d = S_LOCK;
        end else if (&db_q) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (&db_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      press_q <= 1'b0;
      multi_q <= 1'b0;
      key_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      multi_q <= multi_d;
      key_q   <= key_d;
    end
  end

  assign s_n   = db_q;
  assign press = press_q;
  assign multi = multi_q;
  assign key   = key_q;
  assign idle  = (state_q == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed self-checking bench for button_conditioner with D=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int C_D = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_n;
  logic [3:0] s_n;
  logic       press;
  logic [1:0] key;
  logic       multi;
  logic       idle;

  int n_checks;
  int n_fail;
  int press_cnt;
  int multi_cnt;
  int both_cnt;
  int p0;
  int m0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(C_D),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .s_n  (s_n),
    .press(press),
    .key  (key),
    .multi(multi),
    .idle (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor samples 1 time unit after each edge; stimulus acts at 2.
  always @(posedge clk) begin
    #1;
    if (press === 1'b1) press_cnt++;
    if (multi === 1'b1) multi_cnt++;
    if (press === 1'b1 && multi === 1'b1) both_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    press_cnt = 0;
    multi_cnt = 0;
    both_cnt  = 0;
    rst_n     = 1'b0;
    btn_n     = 4'hF;
    step(3);
    check_eq("rst_s_n",   {28'd0, s_n},   32'hF);
    check_eq("rst_press", {31'd0, press}, 32'd0);
    check_eq("rst_multi", {31'd0, multi}, 32'd0);
    check_eq("rst_key",   {30'd0, key},   32'd0);
    check_eq("rst_idle",  {31'd0, idle},  32'd1);
    rst_n = 1'b1;
    step(3);

    // Clean press of button 2
    p0 = press_cnt;
    btn_n = 4'b1011;
    step(5);
    check_eq("clean_s_n_early", {28'd0, s_n}, 32'hF);
    step(1);
    check_eq("clean_s_n",       {28'd0, s_n},   32'hB);
    check_eq("clean_no_press",  {31'd0, press}, 32'd0);
    step(1);
    check_eq("clean_press",     {31'd0, press}, 32'd1);
    check_eq("clean_key",       {30'd0, key},   32'd2);
    check_eq("clean_idle_low",  {31'd0, idle},  32'd0);
    step(1);
    check_eq("clean_press_end", {31'd0, press}, 32'd0);
    step(12);
    btn_n = 4'hF;
    step(12);
    check_eq("clean_rel_s_n",   {28'd0, s_n},   32'hF);
    check_eq("clean_rel_idle",  {31'd0, idle},  32'd1);
    check_eq("clean_npress",    press_cnt - p0, 32'd1);

    // Bounce on button 0: 3 low / 1 high, five times, then hold
    p0 = press_cnt;
    for (int b = 0; b < 5; b++) begin
      btn_n = 4'b1110;
      step(3);
      btn_n = 4'hF;
      step(1);
      check_eq("bounce_s_n", {28'd0, s_n}, 32'hF);
    end
    btn_n = 4'b1110;
    step(6);
    check_eq("bounce_s_n_set",  {28'd0, s_n},   32'hE);
    check_eq("bounce_no_press", press_cnt - p0, 32'd0);
    step(1);
    check_eq("bounce_press",    {31'd0, press}, 32'd1);
    check_eq("bounce_key",      {30'd0, key},   32'd0);
    step(5);
    btn_n = 4'hF;
    step(10);
    check_eq("bounce_npress",   press_cnt - p0, 32'd1);

    // Simultaneous press of buttons 0 and 3
    p0 = press_cnt;
    m0 = multi_cnt;
    btn_n = 4'b0110;
    step(6);
    check_eq("simul_s_n",      {28'd0, s_n},   32'h6);
    step(1);
    check_eq("simul_multi",    {31'd0, multi}, 32'd1);
    check_eq("simul_press",    {31'd0, press}, 32'd0);
    step(1);
    check_eq("simul_multi_end", {31'd0, multi}, 32'd0);
    btn_n = 4'b0111;
    step(10);
    check_eq("simul_half_s_n", {28'd0, s_n},   32'h7);
    check_eq("simul_half_idle", {31'd0, idle}, 32'd0);
    btn_n = 4'hF;
    step(10);
    check_eq("simul_idle",     {31'd0, idle},  32'd1);
    check_eq("simul_nmulti",   multi_cnt - m0, 32'd1);
    check_eq("simul_npress",   press_cnt - p0, 32'd0);

    // Overlap: button 1, then button 3 while 1 is held
    p0 = press_cnt;
    m0 = multi_cnt;
    btn_n = 4'b1101;
    step(7);
    check_eq("ovl_press",      {31'd0, press}, 32'd1);
    check_eq("ovl_key",        {30'd0, key},   32'd1);
    step(3);
    btn_n = 4'b0101;
    step(6);
    check_eq("ovl_s_n",        {28'd0, s_n},   32'h5);
    step(1);
    check_eq("ovl_multi",      {31'd0, multi}, 32'd1);
    check_eq("ovl_no_press",   {31'd0, press}, 32'd0);
    check_eq("ovl_key_hold",   {30'd0, key},   32'd1);
    step(3);
    btn_n = 4'hF;
    step(10);
    check_eq("ovl_idle",       {31'd0, idle},  32'd1);
    check_eq("ovl_nmulti",     multi_cnt - m0, 32'd1);
    check_eq("ovl_npress",     press_cnt - p0, 32'd1);
    check_eq("ovl_key_final",  {30'd0, key},   32'd1);

    // Reset mid-debounce with button 3 held
    btn_n = 4'b0111;
    step(2);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_s_n",       {28'd0, s_n},   32'hF);
    check_eq("mrst_key",       {30'd0, key},   32'd0);
    check_eq("mrst_idle",      {31'd0, idle},  32'd1);
    step(1);
    rst_n = 1'b1;
    p0 = press_cnt;
    step(6);
    check_eq("mrst_s_n_set",   {28'd0, s_n},   32'h7);
    check_eq("mrst_no_press",  press_cnt - p0, 32'd0);
    step(1);
    check_eq("mrst_press",     {31'd0, press}, 32'd1);
    check_eq("mrst_key3",      {30'd0, key},   32'd3);
    step(3);
    btn_n = 4'hF;
    step(10);

    // Back-to-back: button 0 then button 1
    p0 = press_cnt;
    btn_n = 4'b1110;
    step(7);
    check_eq("b2b_press0",     {31'd0, press}, 32'd1);
    check_eq("b2b_key0",       {30'd0, key},   32'd0);
    step(3);
    btn_n = 4'hF;
    step(10);
    check_eq("b2b_idle_gap",   {31'd0, idle},  32'd1);
    btn_n = 4'b1101;
    step(7);
    check_eq("b2b_press1",     {31'd0, press}, 32'd1);
    check_eq("b2b_key1",       {30'd0, key},   32'd1);
    step(3);
    btn_n = 4'hF;
    step(10);
    check_eq("b2b_npress",     press_cnt - p0, 32'd2);
    check_eq("b2b_idle_end",   {31'd0, idle},  32'd1);

    check_eq("press_multi_excl", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
